router_out_port: RTL and testbench
==================================

ROUTER_OUT_PORT -- requirements
Module: router_out_port

Interface
REQ-001 SHALL have: CLK  input  1  clock, all logic on rising edge.
REQ-002 SHALL have: RST  input  1  reset, synchronous, active-high.
REQ-003 SHALL have: enable  input  1  stage enable, active-high.
REQ-004 SHALL have: in_valid  input  4  per-port beat valid, bit i = port i.
REQ-005 SHALL have: in_data  input  32  per-port byte, port i on bits [8i+7:8i].
REQ-006 SHALL have: in_last  input  4  per-port last-beat-of-packet flag.
REQ-007 SHALL have: in_ready  output  4  per-port beat accept.
REQ-008 SHALL have: req_vector  output  4  requests to the 4-way arbiter.
REQ-009 SHALL have: grant_vector  input  4  registered one-hot grant from the arbiter.
REQ-010 SHALL have: out_valid / out_data / out_last  output  1/8/1  output beat.
REQ-011 SHALL have: out_ready  input  1  downstream accept.
REQ-012 SHALL have: busy  output  1  packet in flight; cur_port  output  2  locked port index.
REQ-013 SHALL have: err  output  1  sticky grant error (see Configuration).

Function
REQ-014 States SHALL be IDLE and BUSY; busy = (state==BUSY).
REQ-015 req_vector SHALL be in_valid when state==IDLE and enable=1, else 4'b0000.
REQ-016 prev_req SHALL be a register set to 1 when req_vector!=0 in a cycle, else 0; a grant is qualified only when prev_req=1, since the arbiter output lags its request by one cycle and holds a stale grant otherwise.
REQ-017 IDLE->BUSY SHALL occur when enable=1, prev_req=1, grant_vector one-hot and in_valid[granted]=1; cur_port SHALL load the granted index on that edge.
REQ-018 A grant bit for a port with in_valid=0 SHALL be ignored; state stays IDLE.
REQ-019 in_ready[i] SHALL be 1 only when state==BUSY, cur_port==i, enable=1 and (out_valid==0 or out_ready==1); all other bits 0.
REQ-020 An input beat SHALL transfer when in_valid[i] and in_ready[i] are both 1; its data/last SHALL appear on out_data/out_last with out_valid=1 on the next cycle (latency 1).
REQ-021 out_valid SHALL clear when out_ready=1 and no new beat transfers in that cycle; out_data/out_last SHALL hold while out_valid=1 and out_ready=0.
REQ-022 A transferred beat with in_last=1 SHALL return state to IDLE on the same edge; the next packet start is at least two cycles later (req then qualified grant).
REQ-023 enable=0 SHALL freeze state, cur_port and prev_req, force in_ready and req_vector to 0; a pending output beat SHALL still complete via out_ready.
REQ-024 Throughput SHALL be one beat per cycle while BUSY with out_ready held 1.
REQ-025 Single-beat packet (in_last=1 on first beat) SHALL be supported.

Reset
REQ-026 On RST=1 at a clock edge: state=IDLE, cur_port=0, prev_req=0, out_valid=0, out_data=8'h00, out_last=0, err=0; RST SHALL override enable.
REQ-027 RST mid-packet SHALL abort the packet; the partially forwarded packet is not completed and out_valid drops on the next cycle.

Configuration
REQ-028 Macro ROUTER_GRANT_CHECK_EN SHALL control grant checking.
REQ-029 Defined: in IDLE with prev_req=1, grant_vector that is zero, non-one-hot, or not a subset of the previous req_vector SHALL set err=1 (sticky until RST) and SHALL NOT start a packet.
REQ-030 Undefined: err SHALL be tied 0; a non-one-hot grant SHALL select its lowest set bit, subject to REQ-018.

Verification
REQ-031 Reset: RST=1 for 2 cycles with all inputs toggling -> out_valid=0, out_data=00, busy=0, err=0, req_vector=0000.
REQ-032 Single port: in_valid=0001, 3-beat packet AA,BB,CC(last), grant_vector=0001 one cycle after req -> out bytes AA,BB,CC on consecutive cycles, out_last with CC, busy drops after CC.
REQ-033 Contention: in_valid=0110, grant_vector=0100 -> cur_port=2, in_ready=0100, port 1 held with in_ready[1]=0 until port 2 last; then req_vector=0010.
REQ-034 Backpressure: out_ready=0 for 3 cycles mid-packet -> out_data stable, in_ready=0000, no beat lost or duplicated.
REQ-035 Stale grant: grant_vector=1000 held while returning to IDLE, in_valid[3]=0 -> no packet start; enable=0 for 5 cycles mid-packet -> state and cur_port unchanged.
REQ-036 With ROUTER_GRANT_CHECK_EN: grant_vector=0011 after req 0011 -> err=1, busy=0; without it -> port 0 selected, err=0.

Source files
------------

// File: rtl/router_out_port_if.sv
// rtl/router_out_port_if.sv - handshake bundle between a router output port and its environment
interface router_out_port_if;
   logic        enable;
   logic [3:0]  in_valid;
   logic [31:0] in_data;
   logic [3:0]  in_last;
   logic [3:0]  in_ready;
   logic [3:0]  req_vector;
   logic [3:0]  grant_vector;
   logic        out_valid;
   logic [7:0]  out_data;
   logic        out_last;
   logic        out_ready;
   logic        busy;
   logic [1:0]  cur_port;
   logic        err;

   modport slave (
      input  enable, in_valid, in_data, in_last, grant_vector, out_ready,
      output in_ready, req_vector, out_valid, out_data, out_last, busy, cur_port, err
   );

   modport master (
      output enable, in_valid, in_data, in_last, grant_vector, out_ready,
      input  in_ready, req_vector, out_valid, out_data, out_last, busy, cur_port, err
   );
endinterface

// File: rtl/router_out_port.sv
// rtl/router_out_port.sv - 4:1 packet output port locked to one input per packet
// Define ROUTER_GRANT_CHECK_EN to flag malformed grants on err instead of taking the lowest grant bit.
module router_out_port (
   input  logic             CLK,
   input  logic             RST,
   router_out_port_if.slave bus
);
   localparam logic [0:0] IDLE = 1'b0;
   localparam logic [0:0] BUSY = 1'b1;

   logic [0:0] state_q, state_d;
   logic [1:0] cur_port_q, cur_port_d;
   logic       prev_req_q, prev_req_d;
   logic       out_valid_q, out_valid_d;
   logic [7:0] out_data_q, out_data_d;
   logic       out_last_q, out_last_d;

   logic [3:0] req;
   logic [3:0] ready;
   logic [1:0] gnt_idx;
   logic       gnt_ok;
   logic       qualify;
   logic       start;
   logic       xfer;

`ifdef ROUTER_GRANT_CHECK_EN
   logic [3:0] prev_vec_q, prev_vec_d;
   logic       err_q, err_d;
`endif

   always_comb begin
      req = (state_q == IDLE && bus.enable) ? bus.in_valid : 4'b0000;
      gnt_idx = 2'd0;
      for (int i = 3; i >= 0; i--) begin
         if (bus.grant_vector[i]) gnt_idx = i[1:0];
      end
`ifdef ROUTER_GRANT_CHECK_EN
      gnt_ok = $onehot(bus.grant_vector) && ((bus.grant_vector & ~prev_vec_q) == 4'b0000);
`else
      gnt_ok = |bus.grant_vector;
`endif
      // The arbiter answers last cycle's request, so only trust grant one cycle after a request.
      qualify = (state_q == IDLE) && bus.enable && prev_req_q;
      start   = qualify && gnt_ok && bus.in_valid[gnt_idx];
      ready   = (state_q == BUSY && bus.enable && (!out_valid_q || bus.out_ready))
                ? (4'b0001 << cur_port_q) : 4'b0000;
      xfer    = |(ready & bus.in_valid);
   end

   always_comb begin
      state_d     = state_q;
      cur_port_d  = cur_port_q;
      prev_req_d  = prev_req_q;
      out_valid_d = out_valid_q;
      out_data_d  = out_data_q;
      out_last_d  = out_last_q;
      if (bus.enable) prev_req_d = |req;
      if (start) begin
         state_d    = BUSY;
         cur_port_d = gnt_idx;
      end
      if (xfer) begin
         out_valid_d = 1'b1;
         out_data_d  = bus.in_data[{cur_port_q, 3'b000} +: 8];
         out_last_d  = bus.in_last[cur_port_q];
         if (bus.in_last[cur_port_q]) state_d = IDLE;
      end else if (bus.out_ready) begin
         out_valid_d = 1'b0;
      end
   end

`ifdef ROUTER_GRANT_CHECK_EN
   always_comb begin
      prev_vec_d = bus.enable ? req : prev_vec_q;
      err_d      = err_q | (qualify && !gnt_ok);
   end

   always_ff @(posedge CLK) begin
      if (RST) begin
         prev_vec_q <= 4'b0000;
         err_q      <= 1'b0;
      end else begin
         prev_vec_q <= prev_vec_d;
         err_q      <= err_d;
      end
   end

   assign bus.err = err_q;
`else
   assign bus.err = 1'b0;
`endif

   always_ff @(posedge CLK) begin
      if (RST) begin
         state_q     <= IDLE;
         cur_port_q  <= 2'd0;
         prev_req_q  <= 1'b0;
         out_valid_q <= 1'b0;
         out_data_q  <= 8'h00;
         out_last_q  <= 1'b0;
      end else begin
         state_q     <= state_d;
         cur_port_q  <= cur_port_d;
         prev_req_q  <= prev_req_d;
         out_valid_q <= out_valid_d;
         out_data_q  <= out_data_d;
         out_last_q  <= out_last_d;
      end
   end

   assign bus.req_vector = req;
   assign bus.in_ready   = ready;
   assign bus.out_valid  = out_valid_q;
   assign bus.out_data   = out_data_q;
   assign bus.out_last   = out_last_q;
   assign bus.busy       = (state_q == BUSY);
   assign bus.cur_port   = cur_port_q;
endmodule

// File: tb/tb_router_out_port.sv
// tb/tb_router_out_port.sv - scoreboard bench: per-port packet queues, packet atomicity and hold checks
module tb_router_out_port;
   logic CLK = 1'b0;
   logic RST;
   always #5 CLK = ~CLK;

   router_out_port_if bus ();
   router_out_port dut (.CLK(CLK), .RST(RST), .bus(bus.slave));

   int vectors = 0;
   int miscompares = 0;

   // Beats are {last, data}; data[7:6] carries the source port so the monitor can route it.
   logic [8:0] src_q [4][$];
   logic [8:0] exp_q [4][$];
   logic [3:0] acc;
   logic       arb_auto = 1'b0;
   logic [3:0] arb_grant = 4'b0000;
   logic [3:0] dir_grant = 4'b0000;

   assign bus.grant_vector = arb_auto ? arb_grant : dir_grant;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
      vectors++;
      if (act !== req) begin
         miscompares++;
         $display("FAIL %s: got %0h, required %0h", name, act, req);
      end
   endtask

   task automatic fail_now(input string name, input int act);
      vectors++;
      miscompares++;
      $display("FAIL %s: got %0d, required 0", name, act);
   endtask

   function automatic logic [3:0] pick(input logic [3:0] r);
      int k;
      k = $urandom_range(0, 3);
      for (int j = 0; j < 4; j++) begin
         if (r[(k + j) % 4]) return 4'b0001 << ((k + j) % 4);
      end
      return 4'b0000;
   endfunction

   // Reference arbiter: registered random one-hot grant, holds the stale grant when nobody requests.
   always @(posedge CLK) begin
      if (RST) arb_grant <= 4'b0000;
      else if (bus.req_vector != 4'b0000) arb_grant <= pick(bus.req_vector);
   end

   function automatic int pending();
      return exp_q[0].size() + exp_q[1].size() + exp_q[2].size() + exp_q[3].size();
   endfunction

   task automatic push_beat(input int p, input logic [7:0] d, input logic l);
      src_q[p].push_back({l, d});
      exp_q[p].push_back({l, d});
   endtask

   task automatic push_rand_pkt(input int p);
      int len;
      logic [1:0] pp;
      len = $urandom_range(1, 4);
      pp = p[1:0];
      for (int k = 0; k < len; k++) push_beat(p, {pp, 6'($urandom)}, k == len - 1);
   endtask

   task automatic flush();
      for (int i = 0; i < 4; i++) begin
         src_q[i].delete();
         exp_q[i].delete();
      end
   endtask

   task automatic refresh();
      for (int i = 0; i < 4; i++) begin
         if (src_q[i].size() != 0) begin
            bus.in_valid[i]        = 1'b1;
            bus.in_data[i*8 +: 8]  = src_q[i][0][7:0];
            bus.in_last[i]         = src_q[i][0][8];
         end else begin
            bus.in_valid[i]        = 1'b0;
            bus.in_data[i*8 +: 8]  = 8'($urandom);
            bus.in_last[i]         = 1'($urandom);
         end
      end
   endtask

   task automatic step();
      @(negedge CLK);
      acc = bus.in_valid & bus.in_ready;
      @(posedge CLK);
      #1;
      for (int i = 0; i < 4; i++) if (acc[i] === 1'b1 && src_q[i].size() != 0) void'(src_q[i].pop_front());
      refresh();
      #1;
   endtask

   task automatic drain(input int budget);
      int n = 0;
      while (pending() != 0 && n < budget) begin
         step();
         n++;
      end
      if (pending() != 0) fail_now("drain_timeout", pending());
   endtask

   // Monitor: every accepted output beat must be the head of its port's queue, packets must not interleave.
   logic       held_v = 1'b0;
   logic [8:0] held;
   logic       in_pkt = 1'b0;
   logic [1:0] pkt_port;
   always @(negedge CLK) begin
      if (RST !== 1'b0) begin
         held_v <= 1'b0;
         in_pkt <= 1'b0;
      end else begin
         if (held_v) chk("out_hold", {bus.out_valid, bus.out_last, bus.out_data}, {1'b1, held});
         if (bus.out_valid && bus.out_ready) begin
            if (in_pkt) chk("pkt_atomic_port", 32'(bus.out_data[7:6]), 32'(pkt_port));
            if (exp_q[bus.out_data[7:6]].size() == 0) fail_now("unexpected_beat", int'(bus.out_data));
            else chk("out_beat", {bus.out_last, bus.out_data}, exp_q[bus.out_data[7:6]].pop_front());
            in_pkt   <= !bus.out_last;
            pkt_port <= bus.out_data[7:6];
         end
         held_v <= bus.out_valid && !bus.out_ready;
         held   <= {bus.out_last, bus.out_data};
      end
   end

   initial begin
      #2_000_000;
      fail_now("global_timeout", 1);
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $fatal(1, "timeout");
   end

   initial begin
      RST = 1'b1;
      bus.enable = 1'b1;
      bus.out_ready = 1'b1;
      refresh();
      for (int k = 0; k < 2; k++) begin
         bus.enable    = 1'($urandom);
         bus.out_ready = 1'($urandom);
         bus.in_valid  = 4'($urandom);
         bus.in_data   = $urandom;
         bus.in_last   = 4'($urandom);
         dir_grant     = 4'($urandom);
         #1;
         @(negedge CLK);
         @(posedge CLK);
         #1;
      end
      chk("rst_out_valid", bus.out_valid, 0);
      chk("rst_out_data", bus.out_data, 8'h00);
      chk("rst_busy", bus.busy, 0);
      chk("rst_err", bus.err, 0);
      RST = 1'b0;
      bus.enable = 1'b1;
      bus.out_ready = 1'b1;
      dir_grant = 4'b0000;
      refresh();
      #1;
      chk("rst_req_vector", bus.req_vector, 4'b0000);

      // Single port, three beats, grant one cycle after the request.
      push_beat(0, 8'h2A, 1'b0);
      push_beat(0, 8'h3B, 1'b0);
      push_beat(0, 8'h0C, 1'b1);
      refresh();
      #1;
      chk("t1_req", bus.req_vector, 4'b0001);
      step();
      dir_grant = 4'b0001;
      chk("t1_not_busy_yet", bus.busy, 0);
      step();
      #1;
      chk("t1_busy", bus.busy, 1);
      chk("t1_cur_port", bus.cur_port, 0);
      chk("t1_in_ready", bus.in_ready, 4'b0001);
      step();
      chk("t1_beat0_valid", bus.out_valid, 1);
      step();
      chk("t1_beat1_valid", bus.out_valid, 1);
      step();
      chk("t1_last_valid", bus.out_valid, 1);
      chk("t1_last_flag", bus.out_last, 1);
      chk("t1_busy_drop", bus.busy, 0);

      // Contention between ports 1 and 2, grant to port 2, stale grant 1000 held while returning to idle.
      push_beat(1, 8'h41, 1'b0);
      push_beat(1, 8'h52, 1'b1);
      push_beat(2, 8'h83, 1'b0);
      push_beat(2, 8'h94, 1'b0);
      push_beat(2, 8'hA5, 1'b1);
      refresh();
      #1;
      chk("t2_req", bus.req_vector, 4'b0110);
      step();
      dir_grant = 4'b0100;
      step();
      dir_grant = 4'b1000;
      #1;
      chk("t2_busy", bus.busy, 1);
      chk("t2_cur_port", bus.cur_port, 2);
      for (int k = 0; k < 3; k++) begin
         chk("t2_in_ready", bus.in_ready, 4'b0100);
         step();
      end
      chk("t2_idle_after_last", bus.busy, 0);
      chk("t2_req_port1", bus.req_vector, 4'b0010);
`ifndef ROUTER_GRANT_CHECK_EN
      step();
      step();
      chk("t2_stale_grant_ignored", bus.busy, 0);
      chk("t2_stale_no_err", bus.err, 0);
`endif
      dir_grant = 4'b0010;
      step();
      chk("t2_port1_busy", bus.busy, 1);
      chk("t2_port1_cur", bus.cur_port, 1);
      drain(20);

      // Backpressure then enable freeze on a five-beat packet from port 3.
      for (int k = 0; k < 5; k++) push_beat(3, 8'hC1 + 8'(k), k == 4);
      refresh();
      step();
      dir_grant = 4'b1000;
      step();
      step();
      step();
      bus.out_ready = 1'b0;
      #1;
      for (int k = 0; k < 3; k++) begin
         chk("t3_bp_in_ready", bus.in_ready, 4'b0000);
         chk("t3_bp_valid", bus.out_valid, 1);
         step();
      end
      bus.out_ready = 1'b1;
      step();
      bus.enable = 1'b0;
      #1;
      for (int k = 0; k < 5; k++) begin
         chk("t3_frz_busy", bus.busy, 1);
         chk("t3_frz_cur", bus.cur_port, 3);
         chk("t3_frz_in_ready", bus.in_ready, 4'b0000);
         chk("t3_frz_req", bus.req_vector, 4'b0000);
         step();
      end
      chk("t3_frz_out_done", bus.out_valid, 0);
      bus.enable = 1'b1;
      drain(20);

      // Two-bit grant answering a two-port request, single-beat packets.
      push_beat(0, 8'h11, 1'b1);
      push_beat(1, 8'h62, 1'b1);
      refresh();
      step();
      dir_grant = 4'b0011;
      step();
`ifdef ROUTER_GRANT_CHECK_EN
      chk("t4_err_set", bus.err, 1);
      chk("t4_no_start", bus.busy, 0);
      step();
      chk("t4_err_sticky", bus.err, 1);
      RST = 1'b1;
      step();
      RST = 1'b0;
      flush();
      refresh();
      dir_grant = 4'b0000;
      #1;
      chk("t4_err_cleared", bus.err, 0);
`else
      chk("t4_lowest_busy", bus.busy, 1);
      chk("t4_lowest_port", bus.cur_port, 0);
      chk("t4_no_err", bus.err, 0);
      dir_grant = 4'b0010;
      drain(20);
`endif

      // Reset in the middle of a packet aborts it.
      for (int k = 0; k < 4; k++) push_beat(2, 8'h81 + 8'(k * 17), k == 3);
      refresh();
      step();
      dir_grant = 4'b0100;
      step();
      step();
      step();
      RST = 1'b1;
      step();
      chk("t5_abort_valid", bus.out_valid, 0);
      chk("t5_abort_busy", bus.busy, 0);
      RST = 1'b0;
      flush();
      refresh();
      step();

      // Randomized traffic against the reference arbiter.
      arb_auto = 1'b1;
      for (int c = 0; c < 3000; c++) begin
         for (int p = 0; p < 4; p++) if (src_q[p].size() == 0 && $urandom_range(0, 7) == 0) push_rand_pkt(p);
         bus.enable    = ($urandom_range(0, 9) != 0);
         bus.out_ready = ($urandom_range(0, 3) != 0);
         refresh();
         #1;
         chk("rnd_req", bus.req_vector, (bus.busy || !bus.enable) ? 4'b0000 : bus.in_valid);
         if (!bus.busy || !bus.enable || (bus.out_valid && !bus.out_ready))
            chk("rnd_rdy_gate", bus.in_ready, 4'b0000);
         else
            chk("rnd_rdy_onehot", $countones(bus.in_ready), 1);
         step();
      end
      bus.enable = 1'b1;
      bus.out_ready = 1'b1;
      drain(1000);
      chk("rnd_err_clear", bus.err, 0);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end
endmodule
